imem_loader: RTL and testbench

Boot-time instruction-memory loader: accepts a framed byte stream over a valid/ready interface, assembles big-endian 32-bit words and writes them into the fetch stage's instruction memory starting at word 0 (fetch address 0x3000). It holds the pipeline in reset through `cpu_hold` until a complete, checksum-verified image has been written. It sits between the host/UART byte source and the write port of the instruction memory read by the fetch stage.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the
// boot loader. The loader takes the slave side; the byte source / memory
// side (or a bench) takes the master side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, words_loaded
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Parses a frame of
// LEN_HI, LEN_LO, 4*N data bytes (big-endian words), 8-bit additive checksum;
// writes each word to consecutive instruction-memory addresses from 0 and
// keeps the CPU held in reset until the whole image is written and verified.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input logic         clk,
    input logic         rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_len_hi;
    logic [ADDR_W:0]   r_len;
    logic [23:0]       r_asm;      // first three bytes of the word in flight
    logic [1:0]        r_bcnt;
    logic [7:0]        r_sum;
    logic [ADDR_W:0]   r_words;    // words registered for write so far
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_err;

    logic              w_fire;
    logic [15:0]       w_len;
    logic [ADDR_W:0]   w_words_nxt;
    logic [7:0]        w_sum_nxt;

    assign w_fire      = bus.in_valid && r_ready;
    assign w_len       = {r_len_hi, bus.in_data};
    assign w_words_nxt = r_words + 1'b1;
    assign w_sum_nxt   = r_sum + bus.in_data;

    // Frame parser: header, word assembly/write, checksum; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_LEN_HI;
            r_len_hi <= '0;
            r_len    <= '0;
            r_asm    <= '0;
            r_bcnt   <= '0;
            r_sum    <= '0;
            r_words  <= '0;
            r_ready  <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_hold   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; address/data stay put.
            r_we <= 1'b0;
            if (w_fire) begin
                case (r_state)
                    S_LEN_HI: begin
                        r_len_hi <= bus.in_data;
                        r_state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        if (w_len == 16'd0 || w_len > 16'(DEPTH)) begin
                            r_state <= S_ERR;
                            r_ready <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_len   <= w_len[ADDR_W:0];
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_sum  <= w_sum_nxt;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            // Word complete: r_words < r_len <= DEPTH, so the
                            // address always fits in ADDR_W bits.
                            r_we    <= 1'b1;
                            r_addr  <= r_words[ADDR_W-1:0];
                            r_wdata <= {r_asm, bus.in_data};
                            r_words <= w_words_nxt;
                            if (w_words_nxt == r_len)
                                r_state <= S_CSUM;
                        end else begin
                            r_asm <= {r_asm[15:0], bus.in_data};
                        end
                    end
                    S_CSUM: begin
                        r_ready <= 1'b0;
                        if (bus.in_data == r_sum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready     = r_ready;
    assign bus.im_we        = r_we;
    assign bus.im_addr      = r_addr;
    assign bus.im_wdata     = r_wdata;
    assign bus.cpu_hold     = r_hold;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, bad lengths, gapped
// stream, mid-frame reset and a full-depth image.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    // Record every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (bus.im_we) begin
            wr_addr.push_back(32'(bus.im_addr));
            wr_data.push_back(bus.im_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reset for one edge; returns at the negedge after release.
    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Present one byte for one edge, then 'gap' idle cycles with junk data.
    task automatic send(input logic [7:0] b, input int gap);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hFF;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic done, input logic err,
                              input logic hold, input logic rdy, input int words);
        chk({tag, "_done"}, 32'(bus.done), 32'(done));
        chk({tag, "_err"}, 32'(bus.err), 32'(err));
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(hold));
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'(rdy));
        chk({tag, "_words"}, 32'(bus.words_loaded), 32'(words));
    endtask

    logic [7:0]  frame2[10];
    logic [7:0]  bq[$];
    logic [31:0] w;
    logic [7:0]  s;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // ---- reset state ----
        do_reset();
        chk("rst_we", 32'(bus.im_we), 32'd0);
        chk("rst_addr", 32'(bus.im_addr), 32'd0);
        chk("rst_wdata", bus.im_wdata, 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1, 1'b1, 0);

        // ---- N=2 good frame; checksum 3C+01+34+21+04 = 0x96 ----
        frame2 = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h00, 8'h34, 8'h21, 8'h00, 8'h04};
        for (int i = 0; i < 6; i++) send(frame2[i], 0);
        // first word's write strobe is visible the cycle after its 4th byte
        chk("t1_we_w0", 32'(bus.im_we), 32'd1);
        chk("t1_addr_w0", 32'(bus.im_addr), 32'd0);
        chk("t1_data_w0", bus.im_wdata, 32'h3C010000);
        chk("t1_hold_mid", 32'(bus.cpu_hold), 32'd1);
        for (int i = 6; i < 10; i++) send(frame2[i], 0);
        send(8'h96, 0);   // overlaps the last word's write cycle
        idle(3);
        chk("t1_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t1_a0", wr_addr[0], 32'd0);
            chk("t1_d0", wr_data[0], 32'h3C010000);
            chk("t1_a1", wr_addr[1], 32'd1);
            chk("t1_d1", wr_data[1], 32'h34210004);
        end
        chk_status("t1", 1'b1, 1'b0, 1'b0, 1'b0, 2);

        // ---- same frame, wrong checksum ----
        do_reset();
        for (int i = 0; i < 10; i++) send(frame2[i], 0);
        send(8'h95, 0);
        idle(3);
        chk("t2_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) chk("t2_d1", wr_data[1], 32'h34210004);
        chk_status("t2", 1'b0, 1'b1, 1'b1, 1'b0, 2);

        // ---- zero length ----
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        chk_status("t3", 1'b0, 1'b1, 1'b1, 1'b0, 0);
        send(8'h12, 0);   // ignored: loader no longer ready
        idle(6);
        chk("t3_nwr", 32'(wr_addr.size()), 32'd0);

        // ---- length DEPTH+1 ----
        do_reset();
        send(8'h04, 0);
        send(8'h01, 0);
        chk_status("t4", 1'b0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) send(8'h00, 0);
        idle(2);
        chk("t4_nwr", 32'(wr_addr.size()), 32'd0);

        // ---- N=1 with valid toggling; DE+AD+BE+EF = 0x338 -> 0x38 ----
        do_reset();
        send(8'h00, 1); send(8'h01, 1);
        send(8'hDE, 1); send(8'hAD, 1); send(8'hBE, 1); send(8'hEF, 1);
        chk("t5_hold_pre", 32'(bus.cpu_hold), 32'd1);
        send(8'h38, 1);
        idle(3);
        chk("t5_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t5_a0", wr_addr[0], 32'd0);
            chk("t5_d0", wr_data[0], 32'hDEADBEEF);
        end
        chk_status("t5", 1'b1, 1'b0, 1'b0, 1'b0, 1);

        // ---- reset after two data bytes, then a full N=1 frame ----
        do_reset();
        send(8'h00, 0); send(8'h01, 0); send(8'h11, 0); send(8'h22, 0);
        do_reset();
        chk_status("t6_rst", 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send(8'h00, 0); send(8'h01, 0);
        send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
        send(8'h38, 0);
        idle(3);
        chk("t6_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t6_a0", wr_addr[0], 32'd0);
            chk("t6_d0", wr_data[0], 32'hDEADBEEF);
        end
        chk_status("t6", 1'b1, 1'b0, 1'b0, 1'b0, 1);

        // ---- full-depth image, continuous stream ----
        do_reset();
        bq.delete();
        s = 8'h00;
        bq.push_back(8'h04);
        bq.push_back(8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            w = {8'(i), 8'(i >> 2), 8'hA5, ~8'(i)};
            for (int k = 3; k >= 0; k--) begin
                bq.push_back(w[k*8 +: 8]);
                s = s + w[k*8 +: 8];
            end
        end
        bq.push_back(s);
        foreach (bq[i]) send(bq[i], 0);
        idle(3);
        chk("t7_nwr", 32'(wr_addr.size()), 32'(DEPTH));
        if (wr_addr.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = {8'(i), 8'(i >> 2), 8'hA5, ~8'(i)};
                chk($sformatf("t7_a%0d", i), wr_addr[i], 32'(i));
                chk($sformatf("t7_d%0d", i), wr_data[i], w);
            end
        end
        chk_status("t7", 1'b1, 1'b0, 1'b0, 1'b0, DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
